mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS datapath.
- Accepts one word read or write request at a time from the processor-side address/data mux, which is driven by the control FSM's IorD/MemWrite/IRWrite sequencing.
- Returns a response after a configurable latency.
- Provides word storage, alignment/range checking and a valid/ready handshake on both the request and the response side.

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two, 2..65536.
- LATENCY, 2, cycles from request acceptance to rsp_valid; 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester consumes the response this cycle
- rsp_rdata  output  32  read data; 0 for writes and errored requests
- rsp_error  output  1  request was misaligned or out of range
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE and the latency counter clears.
  - Outputs: req_ready=1 after reset, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0.
  - Storage contents are NOT reset.
  - Reset mid-operation aborts any pending request and drops any pending response.
  - A write already accepted before the reset edge remains committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is accepted, req_addr/req_write are latched, and the error check is evaluated.
  - If LATENCY=1, go to RESP; otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; when the counter reaches 1, go to RESP on the next edge.
  - Net effect: rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1, go to IDLE.
  - req_ready=0 in RESP. The next request can be accepted the cycle after the handshake; no back-to-back overlap, one outstanding request.
- Error check:
  - rsp_error=1 if req_addr[1:0]!=0, or if word index req_addr[31:2] >= DEPTH.
  - An errored write does not modify storage; an errored read returns rsp_rdata=0.
- Writes:
  - Committed to storage at the acceptance edge.
  - The response carries rsp_rdata=0 and the rsp_error status.
- Reads:
  - Data is taken from storage at the word index, captured on the edge entering RESP.
  - Storage index uses req_addr[$clog2(DEPTH)+1:2].
- req_valid while not in IDLE is ignored; the requester must hold the request until req_ready.
- req_valid and rsp_ready are never both meaningful in the same cycle, because req_ready=0 in RESP.

Optional Feature:
- Macro: MIPS_MEM_BYTE_EN.
- Defined:
  - Adds input port req_be[3:0].
  - Writes update only the byte lanes whose enable is 1 (bit0 = bits 7:0).
  - A write with req_be=0 is a no-op but still responds.
  - Reads ignore req_be.
- Undefined:
  - No req_be port.
  - All writes are full-word.

Decomposition:
- Shared package/defines (next to the existing MIPS defines): state encodings RSP_IDLE, RSP_WAIT, RSP_RESP (2 bits); error check widths.
- One natural sub-module: mips_mem_array, holding the DEPTH×32 storage with a synchronous write port (with per-byte enables under the macro) and a read port.
- The FSM, latency counter and error check live in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 with LATENCY=2, rsp_ready=1 -> req accepted cycle 0, rsp_valid cycle 2 with rsp_error=0 and rsp_rdata=0. Then read 0x10 -> rsp_rdata=0xDEADBEEF exactly 2 cycles after acceptance.
- Read addr 0x13 (misaligned) and addr 4*DEPTH (out of range):
  - both give rsp_error=1, rsp_rdata=0;
  - a write to 4*DEPTH leaves word 0 unchanged (read back to confirm).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_error stay stable, req_ready=0, and a req_valid pulse during RESP is ignored. Raise rsp_ready -> IDLE, req_ready=1 the next cycle.
- Reset asserted during WAIT of a read -> next cycle state is IDLE, no rsp_valid ever appears, and prior storage contents are intact on re-read.
- LATENCY=1 and LATENCY=15 builds -> rsp_valid appears exactly 1 and 15 cycles after acceptance.
- With MIPS_MEM_BYTE_EN defined: word=0x11223344, write 0xAABBCCDD with req_be=4'b0101 -> readback 0x11BB33DD; req_be=0 -> word unchanged, response still given.

Source files
------------

// File: rtl/mips_mem_responder_pkg.sv
// rtl/mips_mem_responder_pkg.sv - shared state encodings, widths and the address error check
package mips_mem_responder_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  // Misaligned byte address or word index beyond the populated depth.
  function automatic logic addr_error(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[ADDR_W-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// rtl/mips_mem_array.sv - DEPTH x 32 word storage, synchronous write, combinational read
// MIPS_MEM_BYTE_EN adds per-byte write enables.
module mips_mem_array
  import mips_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MIPS_MEM_BYTE_EN
  input  logic [3:0]        be,
`endif
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
`ifdef MIPS_MEM_BYTE_EN
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
`else
      mem[waddr] <= wdata;
`endif
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - single-outstanding memory responder for the multicycle MIPS datapath
// MIPS_MEM_BYTE_EN adds the req_be byte-lane write enable port.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MIPS_MEM_BYTE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  rsp_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic              lat_err;
  logic [AW-1:0]     lat_idx;

  logic              accept;
  logic              req_err;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rdata;
  logic              sel_write;
  logic              sel_err;
  logic [DATA_W-1:0] rsp_word;

  assign accept  = (state == RSP_IDLE) && req_valid;
  assign req_err = addr_error(req_addr, DEPTH);
  assign req_idx = req_addr[AW+1:2];

  // With LATENCY=1 the response is built on the acceptance edge, before anything is latched.
  assign raddr     = (state == RSP_IDLE) ? req_idx   : lat_idx;
  assign sel_write = (state == RSP_IDLE) ? req_write : lat_write;
  assign sel_err   = (state == RSP_IDLE) ? req_err   : lat_err;
  assign rsp_word  = (sel_write || sel_err) ? '0 : rdata;

  mips_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (accept && req_write && !req_err),
    .waddr (req_idx),
    .wdata (req_wdata),
`ifdef MIPS_MEM_BYTE_EN
    .be    (req_be),
`endif
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RSP_IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_idx;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RSP_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_word;
              rsp_error <= req_err;
            end else begin
              state <= RSP_WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        RSP_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state     <= RSP_RESP;
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_word;
            rsp_error <= lat_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RSP_RESP: begin
          if (rsp_ready) begin
            state     <= RSP_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= RSP_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - scoreboard bench for mips_mem_responder (MIPS_MEM_BYTE_EN aware)
module tb_mips_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_error, busy;
  logic [31:0] rsp_rdata;

  logic        v1, v15;
  logic        rr1, rv1, re1, b1, rr15, rv15, re15, b15;
  logic [31:0] rd1, rd15;

  always #5 clk = ~clk;

  mips_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MIPS_MEM_BYTE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy)
  );

  mips_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MIPS_MEM_BYTE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rv1), .rsp_ready(1'b1), .rsp_rdata(rd1),
    .rsp_error(re1), .busy(b1)
  );

  mips_mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .req_valid(v15), .req_ready(rr15),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MIPS_MEM_BYTE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rv15), .rsp_ready(1'b1), .rsp_rdata(rd15),
    .rsp_error(re15), .busy(b15)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic [3:0]  mask;
    int          idx;
    e.err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    idx   = int'(addr[9:2]);
`ifdef MIPS_MEM_BYTE_EN
    mask = be;
`else
    mask = 4'hf;
`endif
    if (wr) begin
      e.rdata = '0;
      if (!e.err)
        for (int b = 0; b < 4; b++)
          if (mask[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      e.rdata = e.err ? 32'h0 : model[idx];
    end
    return e;
  endfunction

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    sb.push_back(predict(wr, addr, wdata, be));
    #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    e = sb.pop_front();
    check({tag, "_data"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, 32'(rsp_error), 32'(e.err));
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic lat_probe(input logic wr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    int n1, n15;
    check("probe_rdy1", 32'(rr1), 32'd1);
    check("probe_rdy15", 32'(rr15), 32'd1);
    req_write = wr; req_addr = 32'h40; req_wdata = wdata; req_be = 4'hf;
    v1 = 1'b1; v15 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v15 = 1'b0;
    n1 = 0; n15 = 0;
    for (int c = 1; c <= 20; c++) begin
      if (rv1 && n1 == 0) begin
        n1 = c;
        check("l1_data", rd1, exp_rd);
        check("l1_err", 32'(re1), 32'd0);
      end
      if (rv15 && n15 == 0) begin
        n15 = c;
        check("l15_data", rd15, exp_rd);
        check("l15_err", 32'(re15), 32'd0);
      end
      if (c == 5) check("l15_busy", 32'(b15), 32'd1);
      @(posedge clk); #1;
    end
    check("l1_lat", 32'(n1), 32'd1);
    check("l15_lat", 32'(n15), 32'd15);
    check("l1_idle", 32'(b1), 32'd0);
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [31:0] a, d;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = 4'hf; rsp_ready = 1'b1; v1 = 1'b0; v15 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hf, "wr10");
    xact(1'b0, 32'h10, 32'h0, 4'hf, "rd10");
    xact(1'b1, 32'h0, 32'h01234567, 4'hf, "wr0");
    xact(1'b0, 32'h13, 32'h0, 4'hf, "misalign");
    xact(1'b0, 32'(4*DEPTH), 32'h0, 4'hf, "oor_rd");
    xact(1'b1, 32'(4*DEPTH), 32'hFFFFFFFF, 4'hf, "oor_wr");
    xact(1'b0, 32'h0, 32'h0, 4'hf, "rd0_after_oor");
    xact(1'b1, 32'(4*(DEPTH-1)), 32'hA5A5_5A5A, 4'hf, "wr_top");
    xact(1'b0, 32'(4*(DEPTH-1)), 32'h0, 4'hf, "rd_top");

    // Backpressure with an ignored request pulse during RESP
    rsp_ready = 1'b0;
    xact(1'b0, 32'h10, 32'h0, 4'hf, "bp");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_rdata, 32'hDEADBEEF);
      check("bp_err", 32'(rsp_error), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    check("bp_no_ghost", 32'(seen), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hf, "bp_reread");

    // Reset while a read sits in WAIT
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    seen = 1'b0;
    repeat (LAT + 3) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hf, "midrst_reread");

    lat_probe(1'b1, 32'hCAFE0001, 32'h0);
    lat_probe(1'b0, 32'h0, 32'hCAFE0001);

`ifdef MIPS_MEM_BYTE_EN
    xact(1'b1, 32'h20, 32'h11223344, 4'hf, "be_init");
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "be_0101");
    xact(1'b0, 32'h20, 32'h0, 4'hf, "be_rd1");
    check("be_merge", model[8], 32'h11BB33DD);
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "be_none");
    xact(1'b0, 32'h20, 32'h0, 4'b0000, "be_rd2");
`endif

    for (int i = 0; i < 6; i++) begin
      a = {22'h0, 8'($urandom_range(1, DEPTH - 2)), 2'b00};
      d = $urandom;
      xact(1'b1, a, d, 4'hf, "rnd_wr");
      xact(1'b0, a, 32'h0, 4'hf, "rnd_rd");
    end

    n = sb.size();
    check("sb_empty", 32'(n), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
